logic_gen_checker: RTL and testbench

//  Self-checking response monitor for the logic generator units (structural and behavioural).
//  - Drives one captured operand pair through all four logic functions.
//  - Samples the unit's logic_out after a settle delay and compares it with an internal golden model.
//  - Reports per-function mismatches and an overall pass/fail verdict.

---
 rtl/logic_gen_checker.sv | 139 +++++++++++++
 tb/tb_logic_gen_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gen_checker.sv
// Response checker for a logic generator: drives one operand pair through all four functions,
// samples dut_out after SETTLE cycles per function and reports pass, err_count and fail_mask.
module logic_gen_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic [WIDTH-1:0] drv_a,
  output logic [WIDTH-1:0] drv_b,
  output logic [1:0]       drv_func,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_count,
  output logic [3:0]       fail_mask
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CHECK, ST_DONE} state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] drv_a_q, drv_a_d;
  logic [WIDTH-1:0] drv_b_q, drv_b_d;
  logic [1:0]       drv_func_q, drv_func_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_q, err_d;
  logic [3:0]       mask_q, mask_d;

  logic [WIDTH-1:0] golden;
  logic             mismatch;

  always_comb begin
    golden = '0;
    case (drv_func_q)
      2'd0:    golden = drv_a_q & drv_b_q;
      2'd1:    golden = drv_a_q | drv_b_q;
      2'd2:    golden = drv_a_q ^ drv_b_q;
      default: golden = ~drv_a_q;
    endcase
  end

  // Case-inequality so an undriven or X result from the generator is a failure.
  assign mismatch = (dut_out !== golden);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drv_a_d    = drv_a_q;
    drv_b_d    = drv_b_q;
    drv_func_d = drv_func_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    mask_d     = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          drv_a_d    = a_in;
          drv_b_d    = b_in;
          drv_func_d = 2'd0;
          err_d      = 3'd0;
          mask_d     = 4'd0;
          pass_d     = 1'b0;
          cnt_d      = SETTLE_L;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d              = err_q + 3'd1;
          mask_d[drv_func_q] = 1'b1;
        end
        if (drv_func_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          drv_func_d = drv_func_q + 2'd1;
          cnt_d      = SETTLE_L;
          state_d    = ST_WAIT;
        end
      end
      default: begin
        // err_q already includes any mismatch from the final CHECK.
        done_d  = 1'b1;
        pass_d  = (err_q == 3'd0);
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      drv_a_q    <= '0;
      drv_b_q    <= '0;
      drv_func_q <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 3'd0;
      mask_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drv_a_q    <= drv_a_d;
      drv_b_q    <= drv_b_d;
      drv_func_q <= drv_func_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      mask_q     <= mask_d;
    end
  end

  assign drv_a     = drv_a_q;
  assign drv_b     = drv_b_q;
  assign drv_func  = drv_func_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_logic_gen_checker.sv
// Bench for logic_gen_checker: two instances (4-bit/SETTLE=1, 8-bit/SETTLE=3) checking a
// behavioural generator with injectable stuck-at faults; verdicts go through a done-driven scoreboard.
module tb_logic_gen_checker;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [3:0] mask;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: WIDTH=4, SETTLE=1
  logic       start0;
  logic [3:0] a_in0, b_in0, dut_out0, drv_a0, drv_b0;
  logic [1:0] drv_func0;
  logic       busy0, done0, pass0;
  logic [2:0] err0;
  logic [3:0] mask0;
  logic [3:0] sa0_mask, sa1_mask;
  logic [7:0] g0;

  // Instance 1: WIDTH=8, SETTLE=3
  logic       start1;
  logic [7:0] a_in1, b_in1, dut_out1, drv_a1, drv_b1;
  logic [1:0] drv_func1;
  logic       busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] mask1;

  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [7:0] gfun(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    case (f)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign g0       = gfun({4'h0, drv_a0}, {4'h0, drv_b0}, drv_func0);
  assign dut_out0 = (g0[3:0] & ~sa0_mask) | sa1_mask;
  assign dut_out1 = gfun(drv_a1, drv_b1, drv_func1);

  logic_gen_checker #(.WIDTH(4), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_in(a_in0), .b_in(b_in0), .dut_out(dut_out0),
    .drv_a(drv_a0), .drv_b(drv_b0), .drv_func(drv_func0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_mask(mask0));

  logic_gen_checker #(.WIDTH(8), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a_in1), .b_in(b_in1), .dut_out(dut_out1),
    .drv_a(drv_a1), .drv_b(drv_b1), .drv_func(drv_func1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_mask(mask1));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (q0.size() == 0) chk("dut0_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0_pass", pass0, e.pass);
        chk("dut0_err_count", err0, e.err);
        chk("dut0_fail_mask", mask0, e.mask);
        chk("dut0_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_pass", pass1, e.pass);
        chk("dut1_err_count", err1, e.err);
        chk("dut1_fail_mask", mask1, e.mask);
        chk("dut1_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue a start on instance 0; returns at the negedge after acceptance.
  task automatic run0(input logic [3:0] a, input logic [3:0] b, input bit expect_done,
                      input logic ep, input logic [2:0] ee, input logic [3:0] em);
    exp_t e;
    a_in0  = a;
    b_in0  = b;
    start0 = 1'b1;
    e.pass = ep; e.err = ee; e.mask = em; e.cyc = cyc + 10;
    if (expect_done) q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    chk("dut0_busy_after_start", busy0, 1);
    chk("dut0_pass_cleared", pass0, 0);
    chk("dut0_err_cleared", err0, 0);
    chk("dut0_mask_cleared", mask0, 0);
    chk("dut0_drv_a_captured", drv_a0, a);
    chk("dut0_drv_b_captured", drv_b0, b);
    chk("dut0_drv_func_start", drv_func0, 0);
  endtask

  task automatic drain0();
    for (int k = 0; k < 60 && q0.size() != 0; k++) @(negedge clk);
    if (q0.size() != 0) begin
      chk("dut0_done_timeout", q0.size(), 0);
      q0.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic drain1();
    for (int k = 0; k < 80 && q1.size() != 0; k++) @(negedge clk);
    if (q1.size() != 0) begin
      chk("dut1_done_timeout", q1.size(), 0);
      q1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start0 = 1'b0; a_in0 = '0; b_in0 = '0; sa0_mask = '0; sa1_mask = '0;
    start1 = 1'b0; a_in1 = '0; b_in1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {busy0, busy1}, 0);
    chk("rst_done", {done0, done1}, 0);
    chk("rst_pass", {pass0, pass1}, 0);
    chk("rst_err", {err0, err1}, 0);
    chk("rst_mask", {mask0, mask1}, 0);
    chk("rst_drv", {drv_a0, drv_b0, drv_func0, drv_a1, drv_b1, drv_func1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct generator: 0100/1110/1010/1001 all match.
    run0(4'b0110, 4'b1100, 1, 1'b1, 3'd0, 4'b0000);
    drain0();
    chk("dut0_pass_held", pass0, 1);

    // Bit0 stuck at 0: OR, XOR, NOT fail.
    sa0_mask = 4'b0001;
    run0(4'b1010, 4'b0101, 1, 1'b0, 3'd3, 4'b1110);
    drain0();
    sa0_mask = 4'b0000;

    // Restart attempts mid-run are ignored.
    run0(4'b0011, 4'b0101, 1, 1'b1, 3'd0, 4'b0000);
    @(negedge clk);
    a_in0 = 4'b1111; b_in0 = 4'b0000; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("dut0_drv_a_stable", drv_a0, 4'b0011);
    chk("dut0_drv_b_stable", drv_b0, 4'b0101);
    drain0();
    chk("dut0_idle_after_ignored_start", busy0, 0);

    // Reset mid-run: immediate clear, no done pulse.
    run0(4'b1001, 4'b0110, 0, 1'b0, 3'd0, 4'b0000);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_done", done0, 0);
    chk("midrst_pass_err_mask", {pass0, err0, mask0}, 0);
    chk("midrst_drv", {drv_a0, drv_b0, drv_func0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run0(4'b1001, 4'b0110, 1, 1'b1, 3'd0, 4'b0000);
    drain0();

    // Back-to-back: clean run, then bit3 stuck at 1 (only AND 0100 differs).
    run0(4'b0110, 4'b1100, 1, 1'b1, 3'd0, 4'b0000);
    drain0();
    sa1_mask = 4'b1000;
    run0(4'b0110, 4'b1100, 1, 1'b0, 3'd1, 4'b0001);
    drain0();
    sa1_mask = 4'b0000;

    // Wide instance, SETTLE=3: each function held for 3 WAIT cycles plus CHECK.
    a_in1 = 8'b01101100; b_in1 = 8'b11001110; start1 = 1'b1;
    e.pass = 1'b1; e.err = 3'd0; e.mask = 4'b0000; e.cyc = cyc + 18;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("dut1_drv_func_j%0d", j), drv_func1, j / 4);
      chk($sformatf("dut1_busy_j%0d", j), busy1, 1);
      @(negedge clk);
    end
    chk("dut1_drv_a", drv_a1, 8'b01101100);
    drain1();

    chk("dut0_no_leftover", q0.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
